mem_map_ctrl: RTL
=================

// Module: mem_map_ctrl
// PURPOSE
//  Parametrised nano6502 memory-map controller: zero-page control registers, IO-page device
//  decode over N_DEV one-hot selects, ROM overlay, RAM fallback. Adds programmable
//  per-device wait states that stretch CPU RDY. Sits between 65C02 core bus and all slaves.
// PARAMETERS
//  N_DEV     8        IO devices selectable via io_bank_l (index 0 = boot ROM window)
//  WS_W      4        wait-state counter width; max stall 2**WS_W-1 cycles
//  IO_PAGE   8'hFE    high byte of IO window (IO_PAGE<<8 .. +0xFF)
//  ROM_BASE  16'hE000 ROM overlay start; overlay ends at 0xFFFF inclusive
// PORTS
//  clk_i       in   1          system clock
//  rst_n_i     in   1          reset, asynchronous, active-low
//  R_W_n       in   1          CPU read/write_n (0 = write)
//  addr_i      in   16         address qualifying register writes (write-data cycle)
//  addr_w_i    in   16         address used for decode/select
//  data_i      in   8          CPU write data
//  data_o      out  8          ZP register readback, 0 when regs_cs=0
//  regs_cs     out  1          ZP control register selected
//  ram_cs      out  1          RAM select;  ram_we out 1 = ram_cs & ~R_W_n & rdy_o
//  rom_cs      out  1          ROM select
//  dev_cs      out  N_DEV      one-hot IO device select (bit0 unused, ROM via rom_cs)
//  bank_hi_o   out  8          io_bank_h, forwarded to banked devices
//  rdy_o       out  1          CPU RDY; 0 stalls current access
//  fault_irq_o out  1          sticky unmapped-IO fault (ADDR_DEC_FAULT_EN only, else 0)
// BEHAVIOUR
//  ZP regs (write on posedge when R_W_n=0 and addr_i matches; reset 0): 0x0000 io_bank_l,
//   0x0001 io_bank_h, 0x0002 rom_sel, 0x0003 ws_idx, 0x0004 ws_val -> ws[ws_idx] (ws_idx<N_DEV,
//   else write dropped); 0x0004 reads ws[ws_idx]; ws_idx>=N_DEV reads 0.
//  Decode priority on addr_w_i: ZP 0x0000-0x0004 (0x0005-6 with fault) > IO page > ROM (rom_sel==0)
//   > RAM. Exactly one of regs_cs/ram_cs/rom_cs/dev_cs asserted per cycle (or none on fault).
//  IO page: io_bank_l==0 -> rom_cs; 1..N_DEV-1 -> dev_cs[io_bank_l]; >=N_DEV -> ram_cs.
//  Wait states: target ws = ws[io_bank_l] for IO devices, 0 for ZP/RAM/ROM.
//   FSM IDLE/WAIT, cnt WS_W bits. IDLE: ws=N>0 -> rdy_o=0 (comb), cnt<=N-1, ->WAIT; ws=0 -> rdy_o=1.
//   WAIT: rdy_o=(cnt==0); cnt!=0 -> cnt--; cnt==0 -> IDLE. Stall = N cycles, selects held throughout.
//  Back-to-back accesses to the same device each incur N stalls (IDLE re-entered between).
//  ws written mid-stall applies from the next access; current count unaffected.
//  Reset (any time): state IDLE, cnt 0, all regs 0, rdy_o=1, data_o=0, fault_irq_o=0; selects
//   follow decode of reset register values (rom_sel=0 -> ROM overlay active).
// CONFIGURATION
//  ADDR_DEC_FAULT_EN defined: IO page with io_bank_l>=N_DEV asserts no select, data_o=8'hFF,
//   rdy_o=1, sets fault_irq_o and latches addr_w_i into fault_addr (first fault only);
//   ZP 0x0005/0x0006 read fault_addr lo/hi; any write to 0x0005 clears fault_irq_o and fault_addr.
//  Undefined: such accesses fall back to ram_cs; 0x0005/0x0006 are RAM; fault_irq_o tied 0.
// STRUCTURE
//  nano6502_pkg: ZP register address constants, IO device index constants, FSM state encodings.
//  Sub-module ws_timer (load value, start, rdy out, IDLE/WAIT FSM); decode + regs stay top level.
// TESTING
//  Reset, read 0x0000-0x0004 -> all 0; addr 0xE123 -> rom_cs=1; rom_sel=1 -> ram_cs=1.
//  io_bank_l=3, ws_idx=3, ws_val=2, read 0xFE10 -> rdy_o 0,0,1 over 3 cycles, dev_cs=8'h08 held.
//  ws_val=0 for dev 1 at 0xFE00 -> rdy_o stays 1, dev_cs=8'h02 single cycle.
//  Assert rst_n_i in 2nd WAIT cycle -> rdy_o=1 immediately, next access with ws=0 no stall.
//  io_bank_l=9 (N_DEV=8) at 0xFE40: FAULT_EN -> no cs, data_o=FF, fault_irq_o=1, 0x0005=40,0x0006=FE;
//   write 0x0005 -> irq 0. No macro -> ram_cs=1, fault_irq_o=0.
//  ws_idx=8, write ws_val=5 -> no ws changed; read 0x0004 -> 0.

Source files
------------

// File: rtl/mem_map_ctrl_pkg.sv
// Shared constants for the nano6502 memory-map controller: zero-page register map,
// IO device indices and wait-state FSM encoding. ADDR_DEC_FAULT_EN adds the fault registers.
package mem_map_ctrl_pkg;

  localparam logic [15:0] ZP_IO_BANK_L = 16'h0000;
  localparam logic [15:0] ZP_IO_BANK_H = 16'h0001;
  localparam logic [15:0] ZP_ROM_SEL   = 16'h0002;
  localparam logic [15:0] ZP_WS_IDX    = 16'h0003;
  localparam logic [15:0] ZP_WS_VAL    = 16'h0004;
`ifdef ADDR_DEC_FAULT_EN
  localparam logic [15:0] ZP_FAULT_LO  = 16'h0005;
  localparam logic [15:0] ZP_FAULT_HI  = 16'h0006;
`endif

  // IO bank 0 is the boot ROM window rather than a dev_cs device
  localparam logic [7:0] DEV_BOOT_ROM = 8'd0;

  typedef enum logic {
    WS_IDLE = 1'b0,
    WS_WAIT = 1'b1
  } ws_state_e;

endpackage

// File: rtl/mem_map_ctrl_ws_timer.sv
// Wait-state timer: stalls CPU RDY for load_i cycles when an access with a non-zero
// wait-state target starts.
//  state   | meaning
//  WS_IDLE | no stall pending; rdy follows load_i of the current access
//  WS_WAIT | counting down remaining stall cycles; rdy rises when cnt reaches 0
module mem_map_ctrl_ws_timer
  import mem_map_ctrl_pkg::*;
#(
  parameter int WS_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [WS_W-1:0] load_i,
  output logic            rdy_o
);

  localparam logic [WS_W-1:0] ONE = 1;

  ws_state_e       state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_o   = 1'b1;
    case (state_q)
      WS_IDLE: begin
        if (start_i && (load_i != '0)) begin
          rdy_o   = 1'b0;
          cnt_d   = load_i - ONE;
          state_d = WS_WAIT;
        end
      end
      WS_WAIT: begin
        rdy_o = (cnt_q == '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = WS_IDLE;
        end
      end
      default: begin
        state_d = WS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= WS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_map_ctrl.sv
// nano6502 memory-map controller: ZP control regs, IO-page device decode, ROM overlay,
// RAM fallback and per-device wait states. ADDR_DEC_FAULT_EN enables unmapped-IO fault capture.
module mem_map_ctrl
  import mem_map_ctrl_pkg::*;
#(
  parameter int          N_DEV    = 8,
  parameter int          WS_W     = 4,
  parameter logic [7:0]  IO_PAGE  = 8'hFE,
  parameter logic [15:0] ROM_BASE = 16'hE000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             R_W_n,
  input  logic [15:0]      addr_i,
  input  logic [15:0]      addr_w_i,
  input  logic [7:0]       data_i,
  output logic [7:0]       data_o,
  output logic             regs_cs,
  output logic             ram_cs,
  output logic             ram_we,
  output logic             rom_cs,
  output logic [N_DEV-1:0] dev_cs,
  output logic [7:0]       bank_hi_o,
  output logic             rdy_o,
  output logic             fault_irq_o
);

  localparam int         DEV_IDX_W = $clog2(N_DEV);
  localparam logic [7:0] N_DEV_B   = 8'(N_DEV);
`ifdef ADDR_DEC_FAULT_EN
  localparam logic [15:0] ZP_TOP = ZP_FAULT_HI;
`else
  localparam logic [15:0] ZP_TOP = ZP_WS_VAL;
`endif

  logic [7:0]      io_bank_l_q, io_bank_l_d;
  logic [7:0]      io_bank_h_q, io_bank_h_d;
  logic [7:0]      rom_sel_q, rom_sel_d;
  logic [7:0]      ws_idx_q, ws_idx_d;
  logic [WS_W-1:0] ws_q [N_DEV];
  logic [WS_W-1:0] ws_d [N_DEV];

  logic                 wr_en;
  logic                 bank_ok, ws_idx_ok, fault_hit;
  logic [DEV_IDX_W-1:0] bank_idx, ws_sel;
  logic [WS_W-1:0]      ws_tgt;
  logic [7:0]           rd_data;

`ifdef ADDR_DEC_FAULT_EN
  logic        fault_irq_q, fault_irq_d;
  logic [15:0] fault_addr_q, fault_addr_d;
`endif

  assign wr_en     = ~R_W_n;
  assign bank_ok   = io_bank_l_q < N_DEV_B;
  assign bank_idx  = io_bank_l_q[DEV_IDX_W-1:0];
  assign ws_idx_ok = ws_idx_q < N_DEV_B;
  assign ws_sel    = ws_idx_q[DEV_IDX_W-1:0];
  assign bank_hi_o = io_bank_h_q;

  // Decode priority: ZP regs > IO page > ROM overlay > RAM
  always_comb begin
    regs_cs   = 1'b0;
    ram_cs    = 1'b0;
    rom_cs    = 1'b0;
    dev_cs    = '0;
    ws_tgt    = '0;
    fault_hit = 1'b0;
    if (addr_w_i <= ZP_TOP) begin
      regs_cs = 1'b1;
    end else if (addr_w_i[15:8] == IO_PAGE) begin
      if (io_bank_l_q == DEV_BOOT_ROM) begin
        rom_cs = 1'b1;
      end else if (bank_ok) begin
        dev_cs[bank_idx] = 1'b1;
        ws_tgt           = ws_q[bank_idx];
      end else begin
`ifdef ADDR_DEC_FAULT_EN
        fault_hit = 1'b1;
`else
        ram_cs    = 1'b1;
`endif
      end
    end else if ((addr_w_i >= ROM_BASE) && (rom_sel_q == 8'd0)) begin
      rom_cs = 1'b1;
    end else begin
      ram_cs = 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr_w_i)
      ZP_IO_BANK_L: rd_data = io_bank_l_q;
      ZP_IO_BANK_H: rd_data = io_bank_h_q;
      ZP_ROM_SEL:   rd_data = rom_sel_q;
      ZP_WS_IDX:    rd_data = ws_idx_q;
      ZP_WS_VAL:    rd_data = ws_idx_ok ? 8'(ws_q[ws_sel]) : 8'd0;
`ifdef ADDR_DEC_FAULT_EN
      ZP_FAULT_LO:  rd_data = fault_addr_q[7:0];
      ZP_FAULT_HI:  rd_data = fault_addr_q[15:8];
`endif
      default:      rd_data = '0;
    endcase
    if (regs_cs) begin
      data_o = rd_data;
    end else if (fault_hit) begin
      data_o = 8'hFF;
    end else begin
      data_o = 8'h00;
    end
  end

  always_comb begin
    io_bank_l_d = io_bank_l_q;
    io_bank_h_d = io_bank_h_q;
    rom_sel_d   = rom_sel_q;
    ws_idx_d    = ws_idx_q;
    ws_d        = ws_q;
    if (wr_en) begin
      case (addr_i)
        ZP_IO_BANK_L: io_bank_l_d = data_i;
        ZP_IO_BANK_H: io_bank_h_d = data_i;
        ZP_ROM_SEL:   rom_sel_d   = data_i;
        ZP_WS_IDX:    ws_idx_d    = data_i;
        ZP_WS_VAL:    if (ws_idx_ok) ws_d[ws_sel] = data_i[WS_W-1:0];
        default:      ;
      endcase
    end
  end

`ifdef ADDR_DEC_FAULT_EN
  // Only the first unmapped address is kept until software clears it
  always_comb begin
    fault_irq_d  = fault_irq_q;
    fault_addr_d = fault_addr_q;
    if (wr_en && (addr_i == ZP_FAULT_LO)) begin
      fault_irq_d  = 1'b0;
      fault_addr_d = '0;
    end else if (fault_hit) begin
      fault_irq_d = 1'b1;
      if (!fault_irq_q) fault_addr_d = addr_w_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fault_irq_q  <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_irq_q  <= fault_irq_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault_irq_o = fault_irq_q;
`else
  assign fault_irq_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      io_bank_l_q <= '0;
      io_bank_h_q <= '0;
      rom_sel_q   <= '0;
      ws_idx_q    <= '0;
      for (int i = 0; i < N_DEV; i++) ws_q[i] <= '0;
    end else begin
      io_bank_l_q <= io_bank_l_d;
      io_bank_h_q <= io_bank_h_d;
      rom_sel_q   <= rom_sel_d;
      ws_idx_q    <= ws_idx_d;
      ws_q        <= ws_d;
    end
  end

  mem_map_ctrl_ws_timer #(
    .WS_W (WS_W)
  ) u_ws_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (|dev_cs),
    .load_i  (ws_tgt),
    .rdy_o   (rdy_o)
  );

  assign ram_we = ram_cs & ~R_W_n & rdy_o;

endmodule
